// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: groups the run-control, branch-resolution and fetch
// status signals of the fetch sequencer.
//   Control in : start, halt_req, stall, branch_valid, branch_taken,
//                jump_sign, branch_pc, branch_offset
//   Status out : pc, fetch_en, flush, running, done, cycle_count
// The slave modport is the sequencer itself; the master modport is the
// pipeline/run-control side that drives the controls and observes status.
interface fetch_sequencer_if #(
  parameter int PC_W  = 16,
  parameter int CNT_W = 16
);
  logic             start;
  logic             halt_req;
  logic             stall;
  logic             branch_valid;
  logic             branch_taken;
  logic             jump_sign;
  logic [PC_W-1:0]  branch_pc;
  logic [PC_W-1:0]  branch_offset;
  logic [PC_W-1:0]  pc;
  logic             fetch_en;
  logic             flush;
  logic             running;
  logic             done;
  logic [CNT_W-1:0] cycle_count;

  modport slave (
    input  start, halt_req, stall, branch_valid, branch_taken, jump_sign,
           branch_pc, branch_offset,
    output pc, fetch_en, flush, running, done, cycle_count
  );

  modport master (
    output start, halt_req, stall, branch_valid, branch_taken, jump_sign,
           branch_pc, branch_offset,
    input  pc, fetch_en, flush, running, done, cycle_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: run-control and PC sequencing for the instruction fetch
// stage. Owns the program counter, redirects on resolved taken branches,
// squashes wrong-path instructions with a multi-cycle flush pulse, holds on
// hazards and stops on halt. Keeps a saturating run-cycle counter.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - fetch_sequencer_if.slave (controls in, pc/status out)
module fetch_sequencer #(
  parameter int              PC_W         = 16,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 2,
  parameter int              CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [PC_W-1:0]  PC_ONE     = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_CYCLES);

  state_t           state_r, state_s;
  logic [PC_W-1:0]  pc_r, pc_s;
  logic [2:0]       fcnt_r, fcnt_s;
  logic [CNT_W-1:0] cycle_count_r, cycle_count_s;
  logic             flush_r, flush_s;
  logic             running_r, running_s;
  logic             done_r, done_s;
  logic [PC_W-1:0]  target_s;
  logic [CNT_W-1:0] count_inc_s;

  // Branch target arithmetic, modulo 2^PC_W in either direction.
  always_comb begin
    if (bus.jump_sign) begin
      target_s = bus.branch_pc + bus.branch_offset;
    end else begin
      target_s = bus.branch_pc - bus.branch_offset;
    end
  end

  // Saturating increment of the run-cycle counter while running.
  always_comb begin
    if (((state_r == ST_RUN) || (state_r == ST_FLUSH)) && !(&cycle_count_r)) begin
      count_inc_s = cycle_count_r + CNT_ONE;
    end else begin
      count_inc_s = cycle_count_r;
    end
  end

  // Next-state, next-PC and flush counter decision.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    fcnt_s        = fcnt_r;
    cycle_count_s = count_inc_s;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s       = ST_RUN;
          pc_s          = RESET_PC;
          cycle_count_s = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.halt_req) begin
          state_s = ST_HALT;
        end else if (bus.branch_valid && bus.branch_taken) begin
          // A taken branch redirects even if the hazard unit asks to stall.
          state_s = ST_FLUSH;
          pc_s    = target_s;
          fcnt_s  = FLUSH_INIT;
        end else if (bus.branch_valid) begin
          pc_s = bus.branch_pc + PC_ONE;
        end else if (bus.stall) begin
          pc_s = pc_r;
        end else begin
          pc_s = pc_r + PC_ONE;
        end
      end
      ST_FLUSH: begin
        // branch_valid is ignored here: it comes from squashed instructions.
        if (bus.halt_req) begin
          state_s = ST_HALT;
          fcnt_s  = 3'd0;
        end else begin
          fcnt_s = fcnt_r - 3'd1;
          if (fcnt_r <= 3'd1) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_FLUSH;
          end
          if (bus.stall) begin
            pc_s = pc_r;
          end else begin
            pc_s = pc_r + PC_ONE;
          end
        end
      end
      ST_HALT: begin
        if (bus.start) begin
          state_s       = ST_RUN;
          pc_s          = RESET_PC;
          cycle_count_s = '0;
        end else begin
          state_s = ST_HALT;
        end
      end
      default: begin
        state_s = ST_IDLE;
        fcnt_s  = 3'd0;
      end
    endcase
  end

  // Registered status flags derived from the upcoming state.
  always_comb begin
    running_s = (state_s == ST_RUN) || (state_s == ST_FLUSH);
    done_s    = (state_s == ST_HALT);
    flush_s   = (fcnt_s != 3'd0);
  end

  // State, PC, flush counter and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      pc_r          <= RESET_PC;
      fcnt_r        <= 3'd0;
      cycle_count_r <= '0;
      flush_r       <= 1'b0;
      running_r     <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      fcnt_r        <= fcnt_s;
      cycle_count_r <= cycle_count_s;
      flush_r       <= flush_s;
      running_r     <= running_s;
      done_r        <= done_s;
    end
  end

  assign bus.pc          = pc_r;
  assign bus.flush       = flush_r;
  assign bus.running     = running_r;
  assign bus.done        = done_r;
  assign bus.cycle_count = cycle_count_r;
  // Fetch is suppressed combinationally in the same cycle as a stall.
  assign bus.fetch_en    = running_r & ~bus.stall;

endmodule
